// File: rtl/periph_bus_arbiter_if.sv
// Peripheral bus bundle between the arbiter (master)
// and the peripheral fabric (slave).
interface periph_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_valid;
    logic              bus_rnw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_valid,
        output bus_rnw,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ready
    );

    modport slave (
        input  bus_valid,
        input  bus_rnw,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ready
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between
// the CPU memory stage and a debug/loader master, with timeout.
module periph_bus_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_rnw,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_rnw,
    input  logic [ADDR_W-1:0]     dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  dbg_ack,
    output logic                  timeout_err,
    periph_bus_arbiter_if.master  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [DATA_W-1:0] resp_data;
    logic              done;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        valid_d     = valid_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        resp_data   = bus.bus_ready ? bus.bus_rdata : ERR_DATA;
        // Ready wins over a timeout landing in the same cycle.
        done        = bus.bus_ready ||
                      (cnt_q == CNT_W'(TIMEOUT - 1));

        unique case (state_q)
            IDLE: begin
                if (cpu_req && (!dbg_req || last_q == OWN_DBG)) begin
                    owner_d = OWN_CPU;
                    rnw_d   = cpu_rnw;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    valid_d = 1'b1;
                    state_d = BUSY;
                end else if (dbg_req) begin
                    owner_d = OWN_DBG;
                    rnw_d   = dbg_rnw;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                    valid_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = RESP;
                    valid_d = 1'b0;
                    err_d   = !bus.bus_ready;
                    if (owner_q == OWN_CPU) begin
                        cpu_ack_d = 1'b1;
                        if (rnw_q) cpu_rdata_d = resp_data;
                    end else begin
                        dbg_ack_d = 1'b1;
                        if (rnw_q) dbg_rdata_d = resp_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = owner_q;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DBG;
            last_q      <= OWN_DBG;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign bus.bus_valid = valid_q;
    assign bus.bus_rnw   = rnw_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign cpu_ack       = cpu_ack_q;
    assign dbg_ack       = dbg_ack_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign dbg_rdata     = dbg_rdata_q;
    assign timeout_err   = err_q;
    // cpu_ack_q marks RESP with the CPU as owner.
    assign cpu_stall     = cpu_req & ~rst & ~cpu_ack_q;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: vector table
// driven through a scoreboard plus multi-cycle corner sequences.
module tb_periph_bus_arbiter;
    localparam int TO = 15;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_rnw = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dbg_req = 1'b0, dbg_rnw = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic [31:0] dbg_rdata;
    logic        dbg_ack, timeout_err;

    periph_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    periph_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_rnw(dbg_rnw),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .timeout_err(timeout_err),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        who;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] bus_rd;
        logic [31:0] cpu_rd;
        logic [31:0] dbg_rd;
        logic        err;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[10];
    int          nchecks = 0;
    int          nerrors = 0;
    int          busy_n = 0;
    logic        ack_seen = 1'b0;
    logic        noise = 1'b0;
    logic [31:0] cpu_m = '0;
    logic [31:0] dbg_m = '0;

    initial begin
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = '0;
    end

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s act=%h exp=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail1(string name);
        nchecks++;
        nerrors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic push(vec_t v);
        exp_t        e;
        logic        ok;
        logic [31:0] rd;
        ok       = (v.delay >= 1) && (v.delay <= TO);
        e.who    = v.who;
        e.rnw    = v.rnw;
        e.addr   = v.addr;
        e.wdata  = v.wdata;
        e.delay  = v.delay;
        e.bus_rd = v.rdata;
        e.err    = !ok;
        e.busy   = ok ? v.delay : TO;
        rd       = ok ? v.rdata : ERR;
        if (v.rnw) begin
            if (v.who) dbg_m = rd;
            else       cpu_m = rd;
        end
        e.cpu_rd = cpu_m;
        e.dbg_rd = dbg_m;
        sb.push_back(e);
    endtask

    // One clock: monitor the DUT, score acks, act as the peripheral.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus_if.bus_valid) begin
            busy_n++;
            if (sb.size() == 0) begin
                fail1("spurious_valid");
            end else begin
                chk("bus_addr", bus_if.bus_addr, sb[0].addr);
                chk("bus_rnw", 32'(bus_if.bus_rnw),
                    32'(sb[0].rnw));
                if (!sb[0].rnw)
                    chk("bus_wdata", bus_if.bus_wdata, sb[0].wdata);
            end
        end
        chk("ack_onehot", 32'(cpu_ack & dbg_ack), 32'd0);
        if (cpu_ack | dbg_ack) begin
            ack_seen = 1'b1;
            if (sb.size() == 0) begin
                fail1("unexpected_ack");
            end else begin
                e = sb.pop_front();
                chk("ack_who", 32'(dbg_ack), 32'(e.who));
                chk("cpu_rdata", cpu_rdata, e.cpu_rd);
                chk("dbg_rdata", dbg_rdata, e.dbg_rd);
                chk("timeout_err", 32'(timeout_err), 32'(e.err));
                chk("busy_cycles", 32'(busy_n), 32'(e.busy));
            end
            busy_n = 0;
        end else if (timeout_err) begin
            fail1("stray_timeout_err");
        end
        if (bus_if.bus_valid && sb.size() > 0) begin
            bus_if.bus_ready = (busy_n == sb[0].delay);
            bus_if.bus_rdata = sb[0].bus_rd;
        end else begin
            bus_if.bus_ready = noise;
            bus_if.bus_rdata = 32'h0BAD_0BAD;
        end
    endtask

    task automatic run_txn(vec_t v);
        int n;
        push(v);
        if (v.who) begin
            dbg_req = 1'b1; dbg_rnw = v.rnw;
            dbg_addr = v.addr; dbg_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_rnw = v.rnw;
            cpu_addr = v.addr; cpu_wdata = v.wdata;
            #1;
            chk("stall_req", 32'(cpu_stall), 32'd1);
        end
        ack_seen = 1'b0;
        step();
        chk("grant_lat", 32'(bus_if.bus_valid), 32'd1);
        n = 0;
        while (!ack_seen && n < 40) begin
            if (!v.who) chk("stall_busy", 32'(cpu_stall), 32'd1);
            step();
            n++;
        end
        if (!ack_seen) fail1("ack_timeout");
        else if (!v.who) chk("stall_ack", 32'(cpu_stall), 32'd0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        step();
    endtask

    // Both masters request together; CPU re-requests until cpu_n acks.
    task automatic tie_run(int cpu_n);
        int ca;
        int n;
        ca = 0;
        n  = 0;
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 32'h4000_0100;
        dbg_req = 1'b1; dbg_rnw = 1'b1; dbg_addr = 32'h4000_0200;
        while ((cpu_req || dbg_req) && n < 60) begin
            step();
            n++;
            if (cpu_ack) begin
                ca++;
                if (ca == cpu_n) cpu_req = 1'b0;
            end
            if (dbg_ack) dbg_req = 1'b0;
        end
        if (cpu_req || dbg_req) fail1("tie_timeout");
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        step();
        chk("tie_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic vec_t mk(logic who, logic rnw,
                                logic [31:0] addr,
                                logic [31:0] wdata,
                                int delay, logic [31:0] rdata);
        vec_t v;
        v.who = who; v.rnw = rnw; v.addr = addr;
        v.wdata = wdata; v.delay = delay; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        tbl[0] = mk(0, 1, 32'h4000_0010, 0, 2, 32'h1234_5678);
        tbl[1] = mk(1, 0, 32'h4000_0004, 32'hA5A5_A5A5, 1, 0);
        tbl[2] = mk(1, 1, 32'h4000_0008, 0, 3, 32'hCAFE_F00D);
        tbl[3] = mk(1, 0, 32'h4000_000C, 32'h0000_1111, 2, 0);
        tbl[4] = mk(0, 0, 32'h4000_0020, 32'h5A5A_0001, 1, 0);
        tbl[5] = mk(0, 1, 32'h4000_0030, 0, 0, 32'h7777_7777);
        tbl[6] = mk(0, 1, 32'h4000_0034, 0, TO, 32'h0BAD_C0DE);
        tbl[7] = mk(1, 1, 32'h4000_0038, 0, TO - 1, 32'h1357_9BDF);
        tbl[8] = mk(1, 1, 32'h4000_003C, 0, 0, 32'h2468_ACE0);
        tbl[9] = mk(0, 1, 32'h4000_0040, 0, 1, 32'h55AA_33CC);

        // Reset state, with requests pending to expose the stall gating.
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        #1;
        chk("rst_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Tie right after reset: CPU, then debug, then CPU again.
        push(mk(0, 1, 32'h4000_0100, 0, 1, 32'h1111_1111));
        push(mk(1, 1, 32'h4000_0200, 0, 1, 32'h2222_2222));
        push(mk(0, 1, 32'h4000_0100, 0, 1, 32'h3333_3333));
        tie_run(2);

        noise = 1'b1;
        foreach (tbl[i]) run_txn(tbl[i]);
        noise = 1'b0;

        // Async reset during BUSY of a never-answered CPU read.
        push(mk(0, 1, 32'h4000_0050, 0, 0, 32'h0));
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 32'h4000_0050;
        step();
        step();
        step();
        chk("pre_rst_valid", 32'(bus_if.bus_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("arst_stall", 32'(cpu_stall), 32'd0);
        chk("arst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("arst_dbg_ack", 32'(dbg_ack), 32'd0);
        chk("arst_cpu_rdata", cpu_rdata, 32'd0);
        sb.delete();
        busy_n = 0;
        cpu_m = '0;
        dbg_m = '0;
        cpu_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Round-robin history must be cleared by reset.
        push(mk(0, 1, 32'h4000_0100, 0, 2, 32'h4444_4444));
        push(mk(1, 1, 32'h4000_0200, 0, 1, 32'h5555_5555));
        tie_run(1);

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench time limit");
    end
endmodule
